// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared definitions for the codec audio link of the guitar effect chain:
// default sample/slot widths, the DAC sample type and the I2S transmitter
// state encoding.
// -----------------------------------------------------------------------------
package audio_pkg;

    // Width of the signed samples produced by the last effect stage.
    localparam int AUDIO_IN_W      = 32;
    // Width of the signed word sent to the DAC.
    localparam int AUDIO_SAMPLE_W  = 24;
    // BCLK periods per channel slot.
    localparam int AUDIO_SLOT_W    = 32;
    // System clock cycles per BCLK half-period.
    localparam int AUDIO_BCLK_DIV  = 4;

    typedef logic signed [AUDIO_SAMPLE_W-1:0] sample_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tx_state_t;

endpackage

// File: rtl/i2s_tx_chk.sv
// -----------------------------------------------------------------------------
// i2s_tx_chk
// Property checker for i2s_tx. The holding buffer only advertises s_ready while
// empty, so an input handshake can never coincide with a frame load consuming
// the buffer.
//
// Ports:
//   clk, rst  - system clock and synchronous active-high reset
//   handshake - s_valid && s_ready in the transmitter
//   consume   - frame load taking the holding buffer contents
// -----------------------------------------------------------------------------
module i2s_tx_chk (
    input logic clk,
    input logic rst,
    input logic handshake,
    input logic consume
);

    // A new sample must never be accepted on the clk that empties the buffer.
    a_no_hs_on_consume: assert property (
        @(posedge clk) disable iff (rst) !(handshake && consume)
    );

endmodule

// File: rtl/sat_narrow.sv
// -----------------------------------------------------------------------------
// sat_narrow
// Combinational signed saturator from IN_W to SAMPLE_W bits. Values above the
// narrow maximum clamp to max, values below the narrow minimum clamp to min,
// everything else passes through as its low SAMPLE_W bits.
//
// Ports:
//   din  - signed input sample, IN_W bits
//   dout - saturated signed sample, SAMPLE_W bits
// -----------------------------------------------------------------------------
module sat_narrow
    import audio_pkg::*;
#(
    parameter int IN_W     = AUDIO_IN_W,
    parameter int SAMPLE_W = AUDIO_SAMPLE_W
) (
    input  logic signed [IN_W-1:0]     din,
    output logic signed [SAMPLE_W-1:0] dout
);

    // Bits that must all equal the sign for the value to fit in SAMPLE_W.
    localparam int EXT_W = IN_W - SAMPLE_W + 1;

    localparam logic [SAMPLE_W-1:0] SAT_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic [SAMPLE_W-1:0] SAT_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

    logic [EXT_W-1:0] top_s;

    assign top_s = din[IN_W-1:SAMPLE_W-1];

    // Pass through when the upper bits are pure sign extension, else clamp by sign.
    always_comb begin
        if ((top_s == {EXT_W{1'b0}}) || (top_s == {EXT_W{1'b1}})) begin
            dout = din[SAMPLE_W-1:0];
        end else if (din[IN_W-1]) begin
            dout = SAT_MIN;
        end else begin
            dout = SAT_MAX;
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// -----------------------------------------------------------------------------
// i2s_tx
// Philips I2S transmitter for the output side of the guitar effect chain.
// Accepts a stereo pair of signed IN_W samples, saturates each to SAMPLE_W
// bits into a one-entry holding buffer and shifts frames out MSB first with a
// one-bit delay after every LRCLK edge and zero padding to SLOT_W bits.
// BCLK is derived from clk by dividing by 2*BCLK_DIV.
//
// Ports:
//   clk, rst              - system clock, synchronous active-high reset
//   en                    - transmit enable; deassertion stops at frame end
//   s_valid/s_ready       - input handshake for one stereo pair
//   s_left/s_right        - signed input samples
//   i2s_bclk/i2s_lrclk    - bit clock and word select (0 = left)
//   i2s_sdata             - serial data, MSB first
//   frame_start           - one-clk pulse per frame loaded into the shifter
//   underrun              - one-clk pulse when a frame had to repeat the last pair
// -----------------------------------------------------------------------------
module i2s_tx
    import audio_pkg::*;
#(
    parameter int IN_W     = AUDIO_IN_W,
    parameter int SAMPLE_W = AUDIO_SAMPLE_W,
    parameter int SLOT_W   = AUDIO_SLOT_W,
    parameter int BCLK_DIV = AUDIO_BCLK_DIV
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic signed [IN_W-1:0] s_left,
    input  logic signed [IN_W-1:0] s_right,
    output logic                   i2s_bclk,
    output logic                   i2s_lrclk,
    output logic                   i2s_sdata,
    output logic                   frame_start,
    output logic                   underrun
);

    localparam int BIT_W = $clog2(2 * SLOT_W);
    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(2 * SLOT_W - 1);
    localparam logic [BIT_W-1:0] BIT_RIGHT0   = BIT_W'(SLOT_W);
    localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ZERO     = {DIV_W{1'b0}};
    localparam logic [BIT_W-1:0] BIT_ZERO     = {BIT_W{1'b0}};
    localparam logic [SAMPLE_W-1:0] WORD_ZERO = {SAMPLE_W{1'b0}};

    // Serial bit for frame position bit_idx: slot bit b carries word[SAMPLE_W-b]
    // for 1 <= b <= SAMPLE_W; b = 0 is the I2S delay bit and the tail is padding.
    function automatic logic slot_bit(
        input logic [BIT_W-1:0]    bit_idx,
        input logic [SAMPLE_W-1:0] word_l,
        input logic [SAMPLE_W-1:0] word_r
    );
        logic [SAMPLE_W-1:0] word_v;
        logic [SAMPLE_W-1:0] shifted_v;
        int                  b_v;
        if (bit_idx >= BIT_RIGHT0) begin
            word_v = word_r;
            b_v    = int'(bit_idx) - SLOT_W;
        end else begin
            word_v = word_l;
            b_v    = int'(bit_idx);
        end
        if ((b_v >= 1) && (b_v <= SAMPLE_W)) begin
            shifted_v = word_v << (b_v - 1);
            return shifted_v[SAMPLE_W-1];
        end else begin
            return 1'b0;
        end
    endfunction

    tx_state_t           state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic                bclk_q, bclk_d;
    logic                lrclk_q, lrclk_d;
    logic                sdata_q, sdata_d;
    logic                frame_start_q, frame_start_d;
    logic                underrun_q, underrun_d;
    logic                s_ready_q, s_ready_d;
    logic                buf_full_q, buf_full_d;
    logic [SAMPLE_W-1:0] buf_l_q, buf_l_d;
    logic [SAMPLE_W-1:0] buf_r_q, buf_r_d;
    logic [SAMPLE_W-1:0] word_l_q, word_l_d;
    logic [SAMPLE_W-1:0] word_r_q, word_r_d;
    logic [SAMPLE_W-1:0] last_l_q, last_l_d;
    logic [SAMPLE_W-1:0] last_r_q, last_r_d;

    logic signed [SAMPLE_W-1:0] sat_l_s;
    logic signed [SAMPLE_W-1:0] sat_r_s;
    logic                       hs_s;
    logic                       consume_s;
    logic [BIT_W-1:0]           bit_inc_s;

    sat_narrow #(
        .IN_W     (IN_W),
        .SAMPLE_W (SAMPLE_W)
    ) u_sat_l (
        .din  (s_left),
        .dout (sat_l_s)
    );

    sat_narrow #(
        .IN_W     (IN_W),
        .SAMPLE_W (SAMPLE_W)
    ) u_sat_r (
        .din  (s_right),
        .dout (sat_r_s)
    );

    assign hs_s = s_valid && s_ready_q;

    // Holding buffer: store saturated pair on handshake, free it on frame load.
    // s_ready drops with the handshake and only returns one clk after the
    // buffer has been emptied, so it is never high while the buffer is full.
    always_comb begin
        buf_full_d = buf_full_q;
        buf_l_d    = buf_l_q;
        buf_r_d    = buf_r_q;
        if (hs_s) begin
            buf_full_d = 1'b1;
            buf_l_d    = sat_l_s;
            buf_r_d    = sat_r_s;
        end else if (consume_s) begin
            buf_full_d = 1'b0;
        end else begin
            buf_full_d = buf_full_q;
        end
        s_ready_d = ~buf_full_q & ~hs_s;
    end

    // Serializer FSM: BCLK divider, frame bit counter and frame loading.
    // Every output update happens on the fall event (BCLK 1->0). In IDLE the
    // bit counter is parked at the last frame bit so the first fall event in
    // RUN wraps it and loads a frame.
    always_comb begin
        state_d       = state_q;
        div_d         = div_q;
        bit_d         = bit_q;
        bclk_d        = bclk_q;
        lrclk_d       = lrclk_q;
        sdata_d       = sdata_q;
        word_l_d      = word_l_q;
        word_r_d      = word_r_q;
        last_l_d      = last_l_q;
        last_r_d      = last_r_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;
        consume_s     = 1'b0;
        bit_inc_s     = bit_q + BIT_W'(1);
        case (state_q)
            IDLE: begin
                div_d   = DIV_ZERO;
                bit_d   = BIT_LAST;
                bclk_d  = 1'b0;
                lrclk_d = 1'b0;
                sdata_d = 1'b0;
                if (en && buf_full_q) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (div_q == DIV_LAST) begin
                    div_d  = DIV_ZERO;
                    bclk_d = ~bclk_q;
                    if (bclk_q) begin
                        if (bit_q == BIT_LAST) begin
                            if (en) begin
                                bit_d         = BIT_ZERO;
                                lrclk_d       = 1'b0;
                                sdata_d       = 1'b0;
                                frame_start_d = 1'b1;
                                if (buf_full_q) begin
                                    word_l_d  = buf_l_q;
                                    word_r_d  = buf_r_q;
                                    last_l_d  = buf_l_q;
                                    last_r_d  = buf_r_q;
                                    consume_s = 1'b1;
                                end else begin
                                    word_l_d   = last_l_q;
                                    word_r_d   = last_r_q;
                                    underrun_d = 1'b1;
                                end
                            end else begin
                                state_d = IDLE;
                                bit_d   = BIT_LAST;
                                bclk_d  = 1'b0;
                                lrclk_d = 1'b0;
                                sdata_d = 1'b0;
                            end
                        end else begin
                            bit_d   = bit_inc_s;
                            lrclk_d = (bit_inc_s >= BIT_RIGHT0);
                            sdata_d = slot_bit(bit_inc_s, word_l_q, word_r_q);
                        end
                    end else begin
                        bit_d = bit_q;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset for FSM, buffer and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            div_q         <= DIV_ZERO;
            bit_q         <= BIT_ZERO;
            bclk_q        <= 1'b0;
            lrclk_q       <= 1'b0;
            sdata_q       <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            s_ready_q     <= 1'b1;
            buf_full_q    <= 1'b0;
            buf_l_q       <= WORD_ZERO;
            buf_r_q       <= WORD_ZERO;
            word_l_q      <= WORD_ZERO;
            word_r_q      <= WORD_ZERO;
            last_l_q      <= WORD_ZERO;
            last_r_q      <= WORD_ZERO;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            bit_q         <= bit_d;
            bclk_q        <= bclk_d;
            lrclk_q       <= lrclk_d;
            sdata_q       <= sdata_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            s_ready_q     <= s_ready_d;
            buf_full_q    <= buf_full_d;
            buf_l_q       <= buf_l_d;
            buf_r_q       <= buf_r_d;
            word_l_q      <= word_l_d;
            word_r_q      <= word_r_d;
            last_l_q      <= last_l_d;
            last_r_q      <= last_r_d;
        end
    end

    assign i2s_bclk    = bclk_q;
    assign i2s_lrclk   = lrclk_q;
    assign i2s_sdata   = sdata_q;
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;
    assign s_ready     = s_ready_q;

    i2s_tx_chk u_chk (
        .clk       (clk),
        .rst       (rst),
        .handshake (hs_s),
        .consume   (consume_s)
    );

endmodule

// File: tb/tb_i2s_tx.sv
// -----------------------------------------------------------------------------
// tb_i2s_tx
// Directed bench for i2s_tx with BCLK_DIV=2, SLOT_W=32, SAMPLE_W=24. One BCLK
// period is 4 clk, one frame 256 clk. Outputs are sampled 1 time unit after
// the rising clk edge.
// -----------------------------------------------------------------------------
module tb_i2s_tx;

    logic        clk;
    logic        rst;
    logic        en;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_left;
    logic [31:0] s_right;
    logic        i2s_bclk;
    logic        i2s_lrclk;
    logic        i2s_sdata;
    logic        frame_start;
    logic        underrun;

    int n_chk;
    int n_fail;

    localparam logic [63:0] LR_PAT = {32'h0000_0000, 32'hFFFF_FFFF};

    i2s_tx #(
        .IN_W     (32),
        .SAMPLE_W (24),
        .SLOT_W   (32),
        .BCLK_DIV (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_left      (s_left),
        .s_right     (s_right),
        .i2s_bclk    (i2s_bclk),
        .i2s_lrclk   (i2s_lrclk),
        .i2s_sdata   (i2s_sdata),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected 64-bit frame, bit k of the frame at position 63-k.
    function automatic logic [63:0] frame_of(input logic [23:0] l, input logic [23:0] r);
        return {1'b0, l, 7'h00, 1'b0, r, 7'h00};
    endfunction

    task automatic do_reset();
        s_valid = 1'b0;
        en      = 1'b0;
        rst     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_pair(input logic [31:0] l, input logic [31:0] r);
        int n;
        n = 0;
        while (!s_ready && n < 700) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!s_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_pair: s_ready stayed low for %0d cycles", n);
        end
        s_valid = 1'b1;
        s_left  = l;
        s_right = r;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_frame(output int cyc);
        logic found;
        found = 1'b0;
        cyc   = 0;
        while (!found && cyc < 700) begin
            @(posedge clk);
            #1;
            cyc++;
            if (frame_start) found = 1'b1;
        end
        if (!found) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_frame: no frame_start within %0d cycles", cyc);
        end
    endtask

    // Called right after frame_start: samples one bit per BCLK period.
    task automatic capture(output logic [63:0] d, output logic [63:0] lr);
        for (int k = 0; k < 64; k++) begin
            d[63-k]  = i2s_sdata;
            lr[63-k] = i2s_lrclk;
            if (k < 63) begin
                repeat (4) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset();
        s_valid = 1'b0;
        en      = 1'b0;
        s_left  = 32'h0;
        s_right = 32'h0;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        n_chk++; if (i2s_bclk !== 1'b0) begin n_fail++; $display("FAIL reset_bclk: got %b want 0", i2s_bclk); end
        n_chk++; if (i2s_lrclk !== 1'b0) begin n_fail++; $display("FAIL reset_lrclk: got %b want 0", i2s_lrclk); end
        n_chk++; if (i2s_sdata !== 1'b0) begin n_fail++; $display("FAIL reset_sdata: got %b want 0", i2s_sdata); end
        n_chk++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
        n_chk++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start: got %b want 0", frame_start); end
        n_chk++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b want 0", underrun); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int          cyc;
        logic [63:0] d, lr;
        do_reset();
        en = 1'b1;
        send_pair(32'h0012_3456, 32'hFFFF_FFFF);
        wait_frame(cyc);
        n_chk++; if (cyc !== 5) begin n_fail++; $display("FAIL basic_latency: got %0d want 5", cyc); end
        n_chk++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL basic_underrun: got %b want 0", underrun); end
        n_chk++; if (i2s_bclk !== 1'b0) begin n_fail++; $display("FAIL basic_bclk_fall: got %b want 0", i2s_bclk); end
        capture(d, lr);
        n_chk++; if (d !== frame_of(24'h123456, 24'hFFFFFF)) begin n_fail++; $display("FAIL basic_frame: got %h want %h", d, frame_of(24'h123456, 24'hFFFFFF)); end
        n_chk++; if (lr !== LR_PAT) begin n_fail++; $display("FAIL basic_lrclk: got %h want %h", lr, LR_PAT); end
        wait_frame(cyc);
        n_chk++; if (cyc !== 4) begin n_fail++; $display("FAIL basic_period: got %0d want 4", cyc); end
    endtask

    task automatic test_saturation();
        int          cyc;
        logic [63:0] d, lr;
        do_reset();
        en = 1'b1;
        send_pair(32'h0080_0000, 32'hFF00_0000);
        wait_frame(cyc);
        capture(d, lr);
        n_chk++; if (d !== frame_of(24'h7FFFFF, 24'h800000)) begin n_fail++; $display("FAIL sat_clamp: got %h want %h", d, frame_of(24'h7FFFFF, 24'h800000)); end
        send_pair(32'hFF80_0000, 32'h007F_FFFF);
        wait_frame(cyc);
        n_chk++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL sat_underrun: got %b want 0", underrun); end
        capture(d, lr);
        n_chk++; if (d !== frame_of(24'h800000, 24'h7FFFFF)) begin n_fail++; $display("FAIL sat_edge: got %h want %h", d, frame_of(24'h800000, 24'h7FFFFF)); end
    endtask

    task automatic test_back_to_back();
        int          cyc, acc, fs_cnt, fs_cyc, rel;
        logic        rdy, chk_rdy;
        logic [63:0] cap, exp_f;
        do_reset();
        en      = 1'b1;
        acc     = 0;
        fs_cnt  = 0;
        fs_cyc  = 0;
        cyc     = 0;
        chk_rdy = 1'b0;
        cap     = 64'h0;
        s_left  = 32'h0000_1000;
        s_right = 32'hFFFF_F000;
        s_valid = 1'b1;
        while (fs_cnt < 4 && cyc < 1300) begin
            rdy = s_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (rdy) begin
                acc++;
                s_left  = 32'h0000_1000 + 32'(acc);
                s_right = 32'hFFFF_F000 - 32'(acc);
            end
            if (frame_start) begin
                if (fs_cnt > 0) begin
                    exp_f = frame_of(24'h001000 + 24'(fs_cnt - 1), 24'hFFF000 - 24'(fs_cnt - 1));
                    n_chk++; if (cap !== exp_f) begin n_fail++; $display("FAIL b2b_frame%0d: got %h want %h", fs_cnt, cap, exp_f); end
                end
                n_chk++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL b2b_underrun%0d: got %b want 0", fs_cnt, underrun); end
                n_chk++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_at_fs%0d: got %b want 0", fs_cnt, s_ready); end
                fs_cnt++;
                fs_cyc  = cyc;
                chk_rdy = 1'b1;
            end else if (chk_rdy) begin
                n_chk++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_fs%0d: got %b want 1", fs_cnt, s_ready); end
                chk_rdy = 1'b0;
            end
            rel = cyc - fs_cyc;
            if (fs_cnt > 0 && rel < 256 && (rel % 4) == 0) cap[63 - rel / 4] = i2s_sdata;
        end
        s_valid = 1'b0;
        n_chk++; if (fs_cnt !== 4) begin n_fail++; $display("FAIL b2b_frames: got %0d want 4", fs_cnt); end
        n_chk++; if (acc !== 4) begin n_fail++; $display("FAIL b2b_accepted: got %0d want 4", acc); end
    endtask

    task automatic test_underrun();
        int          cyc, n_ur, n_lo;
        logic [63:0] d, lr;
        do_reset();
        en = 1'b1;
        send_pair(32'h0000_0ABC, 32'hFFFF_FF00);
        wait_frame(cyc);
        capture(d, lr);
        n_chk++; if (d !== frame_of(24'h000ABC, 24'hFFFF00)) begin n_fail++; $display("FAIL ur_first: got %h want %h", d, frame_of(24'h000ABC, 24'hFFFF00)); end
        wait_frame(cyc);
        n_chk++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL ur_pulse: got %b want 1", underrun); end
        n_chk++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL ur_ready: got %b want 1", s_ready); end
        capture(d, lr);
        n_chk++; if (d !== frame_of(24'h000ABC, 24'hFFFF00)) begin n_fail++; $display("FAIL ur_repeat: got %h want %h", d, frame_of(24'h000ABC, 24'hFFFF00)); end
        n_ur = 0;
        n_lo = 0;
        for (int i = 0; i < 256; i++) begin
            @(posedge clk);
            #1;
            if (underrun) n_ur++;
            if (!s_ready) n_lo++;
        end
        n_chk++; if (n_ur !== 1) begin n_fail++; $display("FAIL ur_count: got %0d want 1", n_ur); end
        n_chk++; if (n_lo !== 0) begin n_fail++; $display("FAIL ur_ready_low: got %0d want 0", n_lo); end
    endtask

    task automatic test_en_deassert();
        int          cyc, n_fs, n_act;
        logic [63:0] cap, d, lr;
        do_reset();
        en = 1'b1;
        send_pair(32'h0076_5432, 32'h0000_0001);
        wait_frame(cyc);
        cap = 64'h0;
        for (int c = 0; c < 256; c++) begin
            if ((c % 4) == 0) cap[63 - c / 4] = i2s_sdata;
            if (c == 1) begin
                s_valid = 1'b1;
                s_left  = 32'h0001_2345;
                s_right = 32'hFFFE_DCBA;
            end
            if (c == 2) s_valid = 1'b0;
            if (c == 160) en = 1'b0;
            @(posedge clk);
            #1;
        end
        n_chk++; if (cap !== frame_of(24'h765432, 24'h000001)) begin n_fail++; $display("FAIL en_frame: got %h want %h", cap, frame_of(24'h765432, 24'h000001)); end
        n_chk++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL en_boundary_fs: got %b want 0", frame_start); end
        n_chk++; if ({i2s_bclk, i2s_lrclk, i2s_sdata} !== 3'b000) begin n_fail++; $display("FAIL en_boundary_out: got %b want 000", {i2s_bclk, i2s_lrclk, i2s_sdata}); end
        n_fs  = 0;
        n_act = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (frame_start) n_fs++;
            if (i2s_bclk || i2s_lrclk || i2s_sdata) n_act++;
        end
        n_chk++; if (n_fs !== 0) begin n_fail++; $display("FAIL en_idle_fs: got %0d want 0", n_fs); end
        n_chk++; if (n_act !== 0) begin n_fail++; $display("FAIL en_idle_out: got %0d want 0", n_act); end
        n_chk++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL en_buffer_held: got %b want 0", s_ready); end
        en = 1'b1;
        wait_frame(cyc);
        n_chk++; if (cyc !== 5) begin n_fail++; $display("FAIL en_restart_latency: got %0d want 5", cyc); end
        capture(d, lr);
        n_chk++; if (d !== frame_of(24'h012345, 24'hFEDCBA)) begin n_fail++; $display("FAIL en_restart_frame: got %h want %h", d, frame_of(24'h012345, 24'hFEDCBA)); end
    endtask

    task automatic test_reset_mid();
        int          cyc, n_fs;
        logic [63:0] d, lr;
        do_reset();
        en = 1'b1;
        send_pair(32'h0012_3456, 32'hFFFF_FFFF);
        wait_frame(cyc);
        @(posedge clk);
        #1;
        s_valid = 1'b1;
        s_left  = 32'h0000_0055;
        s_right = 32'h0000_00AA;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        repeat (159) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_chk++; if (i2s_bclk !== 1'b0) begin n_fail++; $display("FAIL rmid_bclk: got %b want 0", i2s_bclk); end
        n_chk++; if (i2s_lrclk !== 1'b0) begin n_fail++; $display("FAIL rmid_lrclk: got %b want 0", i2s_lrclk); end
        n_chk++; if (i2s_sdata !== 1'b0) begin n_fail++; $display("FAIL rmid_sdata: got %b want 0", i2s_sdata); end
        n_chk++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_s_ready: got %b want 1", s_ready); end
        n_chk++; if ({frame_start, underrun} !== 2'b00) begin n_fail++; $display("FAIL rmid_pulses: got %b want 00", {frame_start, underrun}); end
        rst  = 1'b0;
        n_fs = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (frame_start || i2s_bclk) n_fs++;
        end
        n_chk++; if (n_fs !== 0) begin n_fail++; $display("FAIL rmid_idle: got %0d want 0", n_fs); end
        send_pair(32'h0000_0F0F, 32'hFFF0_F0F0);
        wait_frame(cyc);
        n_chk++; if (cyc !== 5) begin n_fail++; $display("FAIL rmid_latency: got %0d want 5", cyc); end
        capture(d, lr);
        n_chk++; if (d !== frame_of(24'h000F0F, 24'hF0F0F0)) begin n_fail++; $display("FAIL rmid_frame: got %h want %h", d, frame_of(24'h000F0F, 24'hF0F0F0)); end
        n_chk++; if (lr !== LR_PAT) begin n_fail++; $display("FAIL rmid_lrclk: got %h want %h", lr, LR_PAT); end
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        rst     = 1'b1;
        en      = 1'b0;
        s_valid = 1'b0;
        s_left  = 32'h0;
        s_right = 32'h0;
        test_reset();
        test_basic();
        test_saturation();
        test_back_to_back();
        test_underrun();
        test_en_deassert();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
